// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if
// Bundles the execute-stage request and HI/LO result signals of the
// multiply/divide unit so that both sides can be connected as one port.
//
// Signals:
//   start  - request strobe, only honoured while busy is low
//   op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op1    - multiplicand / dividend (rs)
//   op2    - multiplier / divisor (rt)
//   mthi   - write wdata into HI
//   mtlo   - write wdata into LO
//   wdata  - MTHI/MTLO data
//   busy   - an operation is in flight
//   done   - single-cycle pulse, HI/LO carry the fresh result
//   hi, lo - the architectural HI/LO registers
//
// The master modport is the requester (execute stage or testbench);
// the slave modport is the multiply/divide unit itself.

interface hilo_muldiv_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, op1, op2, mthi, mtlo, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, op1, op2, mthi, mtlo, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv
// Iterative multiply/divide back end that owns the MIPS HI/LO pair.
// A request is latched in IDLE, 32 shift-add (multiply) or restoring
// divide iterations run in RUN, and FIX applies the signs and writes
// HI/LO. Latency from the accepting edge to the result is always 33
// clock edges, independent of operation or operands.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   bus    - hilo_muldiv_if.slave carrying start/op/op1/op2, the
//            MTHI/MTLO write port, busy/done status and HI/LO outputs

module hilo_muldiv (
   input  logic           clk,
   input  logic           reset,
   hilo_muldiv_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state_q, state_d;
   logic [4:0]  count_q;
   logic        isDiv_q;
   logic        negResult_q;
   logic        negRem_q;
   logic        divZero_q;
   logic [63:0] prod_q;
   logic [31:0] rem_q;
   logic [31:0] opB_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   logic        busy;
   logic        accept;
   logic        inRun;
   logic        inFix;

   logic        signedOp;
   logic        negA;
   logic        negB;
   logic [31:0] absA;
   logic [31:0] absB;

   logic [32:0] mulSum;
   logic [63:0] mulNext;
   logic [32:0] divShifted;
   logic [32:0] divDiff;
   logic        quotBit;
   logic [31:0] remNext;
   logic [31:0] quotNext;

   logic [63:0] mulResult;
   logic [31:0] quotResult;
   logic [31:0] remResult;

   // State register: reset always wins, which is how an in-flight
   // operation gets aborted without ever reaching FIX.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: RUN lasts exactly 32 cycles so the latency never
   // depends on operand values.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (count_q == 5'd31) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/control decode from the current state. busy covers RUN and
   // FIX, so the cycle that follows FIX already reports idle and can
   // take the next request in the same cycle that done is high.
   always_comb begin
      busy   = (state_q != IDLE);
      accept = (state_q == IDLE) && bus.start;
      inRun  = (state_q == RUN);
      inFix  = (state_q == FIX);
   end

   // Operand magnitudes. Signed ops work on absolute values and fix up
   // the sign in FIX; the most negative value maps to itself, which is
   // still the correct unsigned magnitude 2^31.
   always_comb begin
      signedOp = ~bus.op[0];
      negA     = signedOp & bus.op1[31];
      negB     = signedOp & bus.op2[31];
      absA     = negA ? (32'd0 - bus.op1) : bus.op1;
      absB     = negB ? (32'd0 - bus.op2) : bus.op2;
   end

   // One iteration of each algorithm. Multiply keeps the multiplier in
   // the low half of the accumulator and shifts the whole thing right,
   // adding the multiplicand into the upper half when the multiplier LSB
   // is set. Divide keeps the dividend in the low half, shifting its MSB
   // into the partial remainder while quotient bits fill in from the
   // right.
   always_comb begin
      mulSum     = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opB_q} : 33'd0);
      mulNext    = {mulSum, prod_q[31:1]};
      divShifted = {rem_q, prod_q[31]};
      divDiff    = divShifted - {1'b0, opB_q};
      quotBit    = ~divDiff[32];
      remNext    = quotBit ? divDiff[31:0] : divShifted[31:0];
      quotNext   = {prod_q[30:0], quotBit};
   end

   // Sign correction applied in FIX. The remainder follows the dividend,
   // the quotient and product follow the XOR of both operand signs.
   always_comb begin
      mulResult  = negResult_q ? (64'd0 - prod_q) : prod_q;
      quotResult = negResult_q ? (32'd0 - prod_q[31:0]) : prod_q[31:0];
      remResult  = negRem_q ? (32'd0 - rem_q) : rem_q;
   end

   // Datapath registers: load on accept, step once per RUN cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= 5'd0;
         isDiv_q     <= 1'b0;
         negResult_q <= 1'b0;
         negRem_q    <= 1'b0;
         divZero_q   <= 1'b0;
         prod_q      <= 64'd0;
         rem_q       <= 32'd0;
         opB_q       <= 32'd0;
      end else if (accept) begin
         count_q     <= 5'd0;
         isDiv_q     <= bus.op[1];
         negResult_q <= negA ^ negB;
         negRem_q    <= negA;
         divZero_q   <= (bus.op2 == 32'd0);
         rem_q       <= 32'd0;
         if (bus.op[1]) begin
            prod_q <= {32'd0, absA};
            opB_q  <= absB;
         end else begin
            prod_q <= {32'd0, absB};
            opB_q  <= absA;
         end
      end else if (inRun) begin
         count_q <= count_q + 5'd1;
         if (isDiv_q) begin
            prod_q <= {prod_q[63:32], quotNext};
            rem_q  <= remNext;
         end else begin
            prod_q <= mulNext;
         end
      end
   end

   // HI/LO registers. FIX has priority, and MTHI/MTLO only land while the
   // unit is idle. A divide by zero leaves both registers untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else if (inFix) begin
         if (!isDiv_q) begin
            hi_q <= mulResult[63:32];
            lo_q <= mulResult[31:0];
         end else if (!divZero_q) begin
            hi_q <= remResult;
            lo_q <= quotResult;
         end
      end else if (!busy) begin
         if (bus.mthi) hi_q <= bus.wdata;
         if (bus.mtlo) lo_q <= bus.wdata;
      end
   end

   // done is registered off FIX so it is high in the cycle where HI/LO
   // first show the new result.
   always_ff @(posedge clk) begin
      if (reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= inFix;
      end
   end

   assign bus.busy = busy;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv
// Directed bench for hilo_muldiv. Each issued request pushes its
// hand-computed HI/LO and the cycle on which done must appear into a
// queue; an independent monitor pops and compares on every done pulse.

module tb_hilo_muldiv;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cycleCount = 0;
   int   testsRun = 0;
   int   testsFailed = 0;
   exp_t sbQueue[$];

   hilo_muldiv_if bus();

   hilo_muldiv dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock and an edge counter used to time done pulses.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Generic comparison helper shared by stimulus and monitor.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drive one request just after a falling edge and record what the
   // result must look like 33 edges after the accepting edge.
   task automatic applyStimulus(input logic [1:0] opV, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expHi,
                                input logic [31:0] expLo);
      exp_t e;
      bus.start = 1'b1;
      bus.op    = opV;
      bus.op1   = a;
      bus.op2   = b;
      @(negedge clk);
      e.hi  = expHi;
      e.lo  = expLo;
      e.cyc = cycleCount + 33;
      sbQueue.push_back(e);
      bus.start = 1'b0;
   endtask

   // Bounded wait for the next done pulse; leaves time at that falling edge.
   task automatic waitDone(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s: done not seen within 100 cycles", name);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request
   // in value and in timing; a pulse with nothing outstanding is an error.
   always @(negedge clk) begin
      if (!reset && bus.done) begin
         if (sbQueue.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpectedDone: done=1 at cycle %0d, expected no pulse",
                     cycleCount);
         end else begin
            exp_t e;
            e = sbQueue.pop_front();
            checkOutput("resultHi", {32'd0, bus.hi}, {32'd0, e.hi});
            checkOutput("resultLo", {32'd0, bus.lo}, {32'd0, e.lo});
            checkOutput("doneCycle", 64'(cycleCount), 64'(e.cyc));
         end
      end
   end

   // Main directed sequence.
   initial begin
      int busyCycles;

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.op1   = 32'd0;
      bus.op2   = 32'd0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
      bus.wdata = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("resetHi",   {32'd0, bus.hi}, 64'd0);
      checkOutput("resetLo",   {32'd0, bus.lo}, 64'd0);
      checkOutput("resetBusy", {63'd0, bus.busy}, 64'd0);
      checkOutput("resetDone", {63'd0, bus.done}, 64'd0);

      // MULTU max*max, counting busy cycles up to the done pulse.
      applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      busyCycles = bus.busy ? 1 : 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
         busyCycles++;
      end
      checkOutput("busyCycles", 64'(busyCycles), 64'd33);
      checkOutput("doneWhenIdle", {63'd0, bus.done}, 64'd1);

      // Back-to-back ops, each issued in the done cycle of the previous one.
      applyStimulus(2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
      waitDone("multNeg");
      applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      waitDone("divNeg");
      applyStimulus(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      waitDone("divu");
      applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
      waitDone("divOverflow");

      // MTHI/MTLO while idle, then divide by zero must preserve them.
      @(negedge clk);
      bus.mthi  = 1'b1;
      bus.wdata = 32'h00001234;
      @(negedge clk);
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b1;
      bus.wdata = 32'h00005678;
      @(negedge clk);
      bus.mtlo  = 1'b0;
      checkOutput("mthiWrite", {32'd0, bus.hi}, 64'h1234);
      checkOutput("mtloWrite", {32'd0, bus.lo}, 64'h5678);
      applyStimulus(2'b11, 32'd9, 32'd0, 32'h00001234, 32'h00005678);
      waitDone("divZero");

      // While running: a second start and an MTHI must both be ignored.
      applyStimulus(2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b11;
      bus.op1   = 32'd1;
      bus.op2   = 32'd1;
      bus.mthi  = 1'b1;
      bus.wdata = 32'h0000DEAD;
      @(negedge clk);
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      checkOutput("mthiIgnored", {32'd0, bus.hi}, 64'h1234);
      checkOutput("busyDuringRun", {63'd0, bus.busy}, 64'd1);
      waitDone("ignoreWhileBusy");
      applyStimulus(2'b00, 32'd5, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC);
      waitDone("nextAfterIgnore");

      // Reset in the middle of a MULT aborts it with no done pulse.
      @(negedge clk);
      applyStimulus(2'b00, 32'd7, 32'd7, 32'd0, 32'd49);
      void'(sbQueue.pop_back());
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abortHi",   {32'd0, bus.hi}, 64'd0);
      checkOutput("abortLo",   {32'd0, bus.lo}, 64'd0);
      checkOutput("abortBusy", {63'd0, bus.busy}, 64'd0);
      checkOutput("abortDone", {63'd0, bus.done}, 64'd0);
      repeat (40) @(negedge clk);

      // The unit must work normally after the abort.
      applyStimulus(2'b01, 32'h00010000, 32'h00010000, 32'd1, 32'd0);
      waitDone("afterAbort");

      @(negedge clk);
      checkOutput("scoreboardEmpty", 64'(sbQueue.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
